// File: rtl/core_pkg.sv
// Shared types for the integer execute reservation station: widths, micro-op
// encodings, the station entry layout and the result-bus wakeup helper.
package core_pkg;

    localparam int ROBID_W = 8;
    localparam int OP_W    = 5;

    // ALU and branch micro-op encodings carried through the station untouched.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_BEQ  = 5'd16,
        OP_BNE  = 5'd17,
        OP_BLT  = 5'd18,
        OP_BGE  = 5'd19,
        OP_BLTU = 5'd20,
        OP_BGEU = 5'd21
    } alu_op_e;

    // One station slot. When rN is 0, opN[ROBID_W-1:0] holds the producer tag.
    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic [ROBID_W-1:0] robid;
        logic [5:0]         rd;
        logic               r1;
        logic [31:0]        op1;
        logic               r2;
        logic [31:0]        op2;
        logic [31:0]        imm;
    } exers_entry_t;

    // Capture a broadcast result into any operand still waiting on that tag.
    // Ready operands are never touched, so a stale tag match cannot clobber a value.
    function automatic exers_entry_t exers_wakeup(
        input exers_entry_t       e,
        input logic               wb_valid,
        input logic [ROBID_W-1:0] wb_robid,
        input logic [31:0]        wb_result
    );
        exers_entry_t r;
        r = e;
        if (e.valid && wb_valid) begin
            if (!e.r1 && (e.op1[ROBID_W-1:0] == wb_robid)) begin
                r.r1  = 1'b1;
                r.op1 = wb_result;
            end
            if (!e.r2 && (e.op2[ROBID_W-1:0] == wb_robid)) begin
                r.r2  = 1'b1;
                r.op2 = wb_result;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/exers_select.sv
// Oldest-ready picker: isolates the lowest set bit of the ready vector.
// Index 0 is the oldest slot, so the lowest set bit is the oldest ready entry.
module exers_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] i_ready_vec,
    output logic [DEPTH-1:0] o_onehot,
    output logic             o_found
);

    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    always_comb begin
        o_onehot = i_ready_vec & (~i_ready_vec + ONE);
        o_found  = |i_ready_vec;
    end

endmodule

// File: rtl/exers.sv
// Integer execute reservation station. Collapsing queue of DEPTH slots (slot 0
// oldest) fed by rename, woken by the CDB, draining the oldest fully-ready op
// into a single registered issue stage toward the ALU.
//
// Handshakes: rename writes are taken when rename_exers_write=1 and
// exers_stall=0 at a rising edge (stall depends only on the registered count).
// The ALU consumes the issue register when exers_issue_valid=1 and alu_ready=1
// at a rising edge; issue fields hold steady while valid and not consumed.
module exers
    import core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rename_exers_write,
    input  logic [OP_W-1:0]    rename_op,
    input  logic [ROBID_W-1:0] rename_robid,
    input  logic [5:0]         rename_rd,
    input  logic               rename_op1ready,
    input  logic [31:0]        rename_op1,
    input  logic               rename_op2ready,
    input  logic [31:0]        rename_op2,
    input  logic [31:0]        rename_imm,
    output logic               exers_stall,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [31:0]        wb_result,
    output logic               exers_issue_valid,
    output logic [OP_W-1:0]    exers_issue_op,
    output logic [ROBID_W-1:0] exers_issue_robid,
    output logic [5:0]         exers_issue_rd,
    output logic [31:0]        exers_issue_op1,
    output logic [31:0]        exers_issue_op2,
    output logic [31:0]        exers_issue_imm,
    input  logic               alu_ready,
    input  logic               rob_flush
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    exers_entry_t       r_entries [DEPTH];
    logic [CNT_W-1:0]   r_count;

    logic               r_issue_valid;
    logic [OP_W-1:0]    r_issue_op;
    logic [ROBID_W-1:0] r_issue_robid;
    logic [5:0]         r_issue_rd;
    logic [31:0]        r_issue_op1;
    logic [31:0]        r_issue_op2;
    logic [31:0]        r_issue_imm;

    // Slot DEPTH is a permanently empty source for the top slot during a shift.
    exers_entry_t       w_woken [DEPTH+1];
    exers_entry_t       w_next  [DEPTH];
    exers_entry_t       w_new_raw;
    exers_entry_t       w_new;
    logic [DEPTH-1:0]   w_ready_vec;
    logic [DEPTH-1:0]   w_onehot;
    logic [DEPTH-1:0]   w_shift_mask;
    logic               w_found;
    logic               w_accept;
    logic               w_issue_fire;
    logic [CNT_W-1:0]   w_wr_idx;
    logic [CNT_W-1:0]   w_count_next;
    logic [OP_W-1:0]    w_sel_op;
    logic [ROBID_W-1:0] w_sel_robid;
    logic [5:0]         w_sel_rd;
    logic [31:0]        w_sel_op1;
    logic [31:0]        w_sel_op2;
    logic [31:0]        w_sel_imm;

    assign exers_stall  = (r_count == FULL_CNT);
    assign w_accept     = rename_exers_write & ~exers_stall;
    assign w_issue_fire = (~r_issue_valid | alu_ready) & w_found;

    // Readiness uses registered operand bits only; a wakeup now is eligible next cycle.
    always_comb begin
        w_ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready_vec[i] = r_entries[i].valid & r_entries[i].r1 & r_entries[i].r2;
        end
    end

    exers_select #(
        .DEPTH(DEPTH)
    ) u_select (
        .i_ready_vec(w_ready_vec),
        .o_onehot   (w_onehot),
        .o_found    (w_found)
    );

    // Incoming op, with the same tag compare so a same-cycle broadcast is not missed.
    always_comb begin
        w_new_raw       = '0;
        w_new_raw.valid = 1'b1;
        w_new_raw.op    = rename_op;
        w_new_raw.robid = rename_robid;
        w_new_raw.rd    = rename_rd;
        w_new_raw.r1    = rename_op1ready;
        w_new_raw.op1   = rename_op1;
        w_new_raw.r2    = rename_op2ready;
        w_new_raw.op2   = rename_op2;
        w_new_raw.imm   = rename_imm;
        w_new           = exers_wakeup(w_new_raw, wb_valid, wb_robid, wb_result);
    end

    // Apply CDB wakeup to every slot and mux out the selected slot's fields.
    always_comb begin
        w_woken[DEPTH] = '0;
        w_sel_op       = '0;
        w_sel_robid    = '0;
        w_sel_rd       = '0;
        w_sel_op1      = '0;
        w_sel_op2      = '0;
        w_sel_imm      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_woken[i] = exers_wakeup(r_entries[i], wb_valid, wb_robid, wb_result);
            if (w_onehot[i]) begin
                w_sel_op    = r_entries[i].op;
                w_sel_robid = r_entries[i].robid;
                w_sel_rd    = r_entries[i].rd;
                w_sel_op1   = r_entries[i].op1;
                w_sel_op2   = r_entries[i].op2;
                w_sel_imm   = r_entries[i].imm;
            end
        end
    end

    // Slots at or above the selected one move down when it leaves.
    always_comb begin
        w_shift_mask    = '0;
        w_shift_mask[0] = w_onehot[0];
        for (int i = 1; i < DEPTH; i++) begin
            w_shift_mask[i] = w_shift_mask[i-1] | w_onehot[i];
        end
    end

    // Next slot contents: collapse on issue, then append at the post-shift tail.
    always_comb begin
        w_wr_idx     = r_count - {{(CNT_W-1){1'b0}}, w_issue_fire};
        w_count_next = w_wr_idx + {{(CNT_W-1){1'b0}}, w_accept};
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue_fire && w_shift_mask[i]) begin
                w_next[i] = w_woken[i+1];
            end else begin
                w_next[i] = w_woken[i];
            end
            if (w_accept && (w_wr_idx == CNT_W'(i))) begin
                w_next[i] = w_new;
            end
        end
    end

    // Slot array and occupancy; flush empties the station ahead of everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_count <= '0;
        end else if (rob_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end

    // Issue register: reload on a pick, drain when the ALU takes it and nothing follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_robid <= '0;
            r_issue_rd    <= '0;
            r_issue_op1   <= '0;
            r_issue_op2   <= '0;
            r_issue_imm   <= '0;
        end else if (rob_flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_issue_fire) begin
            r_issue_valid <= 1'b1;
            r_issue_op    <= w_sel_op;
            r_issue_robid <= w_sel_robid;
            r_issue_rd    <= w_sel_rd;
            r_issue_op1   <= w_sel_op1;
            r_issue_op2   <= w_sel_op2;
            r_issue_imm   <= w_sel_imm;
        end else if (alu_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign exers_issue_valid = r_issue_valid;
    assign exers_issue_op    = r_issue_op;
    assign exers_issue_robid = r_issue_robid;
    assign exers_issue_rd    = r_issue_rd;
    assign exers_issue_op1   = r_issue_op1;
    assign exers_issue_op2   = r_issue_op2;
    assign exers_issue_imm   = r_issue_imm;

endmodule
